// File: rtl/hazard_ctrl_unit_if.sv
// Instruction-class package and the hazard-unit pipeline interface.
// master = pipeline side (drives stage info), slave = hazard unit.
package rv32i_pkg;
  typedef enum logic [2:0] {
    R_TYPE, I_TYPE_ALU, I_TYPE_LOAD, I_TYPE_JALR, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } instr_type_t;
endpackage

interface hazard_ctrl_unit_if #(
  parameter int REG_WIDTH = 5,
  parameter int CNT_WIDTH = 16
);
  rv32i_pkg::instr_type_t instr_typeE;
  logic [REG_WIDTH-1:0]   rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic                   regwriteM, regwriteW;
  logic                   PCSrcE, mdu_startE, mdu_done;
  logic                   stallF, stallD, stallE;
  logic                   flushD, flushE, flushM;
  logic [1:0]             forwardAE, forwardBE;
  logic [CNT_WIDTH-1:0]   stall_cnt;

  modport master (
    output instr_typeE, rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
           regwriteM, regwriteW, PCSrcE, mdu_startE, mdu_done,
    input  stallF, stallD, stallE, flushD, flushE, flushM,
           forwardAE, forwardBE, stall_cnt
  );

  modport slave (
    input  instr_typeE, rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
           regwriteM, regwriteW, PCSrcE, mdu_startE, mdu_done,
    output stallF, stallD, stallE, flushD, flushE, flushM,
           forwardAE, forwardBE, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: operand forwarding, load-use and mul/div stalls,
// branch flushes, and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
  parameter int REG_WIDTH    = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave hz
);
  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MDU_WAIT   = 2'd2;

  logic [1:0]           state, stateNext;
  logic [1:0]           latCnt, latCntNext;
  logic [CNT_WIDTH-1:0] stallCnt;
  logic                 loadUse;
  logic                 sF, sD, sE, fD, fE, fM;
  logic [1:0]           fwdA, fwdB;

  // Memory stage is younger than Writeback, so it wins when both match.
  function automatic logic [1:0] fwdSel(
    input logic [REG_WIDTH-1:0] rs,
    input logic [REG_WIDTH-1:0] rdMem,
    input logic                 wrMem,
    input logic [REG_WIDTH-1:0] rdWb,
    input logic                 wrWb
  );
    if (wrMem && rdMem != '0 && rdMem == rs)     return 2'b10;
    else if (wrWb && rdWb != '0 && rdWb == rs)   return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    fwdA = fwdSel(hz.rs1E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);
    fwdB = fwdSel(hz.rs2E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);
  end

  assign loadUse = (hz.instr_typeE == rv32i_pkg::I_TYPE_LOAD) && (hz.rdE != '0) &&
                   ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  always_comb begin
    stateNext  = state;
    latCntNext = latCnt;
    sF = 1'b0; sD = 1'b0; sE = 1'b0;
    fD = 1'b0; fE = 1'b0; fM = 1'b0;
    case (state)
      RUN: begin
        if (hz.PCSrcE) begin
          fD = 1'b1;
          fE = 1'b1;
        end else if (loadUse) begin
          sF = 1'b1; sD = 1'b1; fE = 1'b1;
          if (LOAD_LATENCY > 1) begin
            stateNext  = LOAD_STALL;
            latCntNext = 2'(LOAD_LATENCY - 1);
          end
        end else if (hz.mdu_startE && !hz.mdu_done) begin
          sF = 1'b1; sD = 1'b1; sE = 1'b1; fM = 1'b1;
          stateNext = MDU_WAIT;
        end
      end
      LOAD_STALL: begin
        sF = 1'b1; sD = 1'b1; fE = 1'b1;
        latCntNext = latCnt - 2'd1;
        if (latCnt <= 2'd1) begin
          stateNext  = RUN;
          latCntNext = 2'd0;
        end
      end
      MDU_WAIT: begin
        if (hz.mdu_done) begin
          stateNext = RUN;
        end else begin
          sF = 1'b1; sD = 1'b1; sE = 1'b1; fM = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      latCnt   <= 2'd0;
      stallCnt <= '0;
    end else begin
      state  <= stateNext;
      latCnt <= latCntNext;
      if (sF && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
    end
  end

  // Reset gates the outputs directly so an in-flight stall drops without a clock.
  assign hz.stallF    = sF & ~rst;
  assign hz.stallD    = sD & ~rst;
  assign hz.stallE    = sE & ~rst;
  assign hz.flushD    = fD & ~rst;
  assign hz.flushE    = fE & ~rst;
  assign hz.flushM    = fM & ~rst;
  assign hz.forwardAE = rst ? 2'b00 : fwdA;
  assign hz.forwardBE = rst ? 2'b00 : fwdB;
  assign hz.stall_cnt = stallCnt;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: two units (LOAD_LATENCY 1 with a 3-bit counter, and 3 with 16 bits)
// share the same stimulus; expected values are hand-computed.
module tb_hazard_ctrl_unit;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_WIDTH(5), .CNT_WIDTH(3))  ifc1 ();
  hazard_ctrl_unit_if #(.REG_WIDTH(5), .CNT_WIDTH(16)) ifc3 ();

  hazard_ctrl_unit #(.REG_WIDTH(5), .LOAD_LATENCY(1), .CNT_WIDTH(3))  u1 (.clk(clk), .rst(rst), .hz(ifc1));
  hazard_ctrl_unit #(.REG_WIDTH(5), .LOAD_LATENCY(3), .CNT_WIDTH(16)) u3 (.clk(clk), .rst(rst), .hz(ifc3));

  int nVec = 0;
  int nErr = 0;

  instr_type_t typeE;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic        regwriteM, regwriteW, PCSrcE, mduStart, mduDone;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    ifc1.instr_typeE = typeE;    ifc3.instr_typeE = typeE;
    ifc1.rs1D = rs1D;            ifc3.rs1D = rs1D;
    ifc1.rs2D = rs2D;            ifc3.rs2D = rs2D;
    ifc1.rs1E = rs1E;            ifc3.rs1E = rs1E;
    ifc1.rs2E = rs2E;            ifc3.rs2E = rs2E;
    ifc1.rdE = rdE;              ifc3.rdE = rdE;
    ifc1.rdM = rdM;              ifc3.rdM = rdM;
    ifc1.rdW = rdW;              ifc3.rdW = rdW;
    ifc1.regwriteM = regwriteM;  ifc3.regwriteM = regwriteM;
    ifc1.regwriteW = regwriteW;  ifc3.regwriteW = regwriteW;
    ifc1.PCSrcE = PCSrcE;        ifc3.PCSrcE = PCSrcE;
    ifc1.mdu_startE = mduStart;  ifc3.mdu_startE = mduStart;
    ifc1.mdu_done = mduDone;     ifc3.mdu_done = mduDone;
  endtask

  task automatic idle();
    typeE = R_TYPE;
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    regwriteM = 1'b0; regwriteW = 1'b0; PCSrcE = 1'b0; mduStart = 1'b0; mduDone = 1'b0;
    apply();
  endtask

  task automatic loadUse(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    typeE = I_TYPE_LOAD; rdE = rd; rs1D = r1; rs2D = r2;
    apply();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset with live hazard and forwarding stimulus: everything must stay quiet
    rst = 1'b1;
    idle();
    loadUse(5'd2, 5'd2, 5'd0);
    rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1; mduStart = 1'b1; apply();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stallF",  {31'b0, ifc3.stallF}, 0);
    chk("rst_flushE",  {31'b0, ifc1.flushE}, 0);
    chk("rst_flushM",  {31'b0, ifc3.flushM}, 0);
    chk("rst_fwdA",    {30'b0, ifc1.forwardAE}, 0);
    chk("rst_cnt3",    {16'b0, ifc3.stall_cnt}, 0);
    idle();
    rst = 1'b0;
    tick();

    // load-use, rs1 match
    loadUse(5'd2, 5'd2, 5'd0); #1;
    chk("lu1_stallF",  {31'b0, ifc1.stallF}, 1);
    chk("lu1_stallD",  {31'b0, ifc1.stallD}, 1);
    chk("lu1_flushE",  {31'b0, ifc1.flushE}, 1);
    chk("lu1_stallE",  {31'b0, ifc1.stallE}, 0);
    chk("lu3_stallF",  {31'b0, ifc3.stallF}, 1);
    tick();
    idle(); PCSrcE = 1'b1; apply(); #1;        // branch must be ignored while LOAD_STALL
    chk("lu1_cnt",     {29'b0, ifc1.stall_cnt}, 1);
    chk("lu1_done",    {31'b0, ifc1.stallF}, 0);
    chk("lu3_state",   {30'b0, u3.state}, 1);
    chk("lu3_c1",      {31'b0, ifc3.stallF}, 1);
    chk("lu3_noflD",   {31'b0, ifc3.flushD}, 0);
    tick();
    idle(); #1;
    chk("lu3_c2",      {31'b0, ifc3.flushE}, 1);
    tick();
    #1;
    chk("lu3_end",     {31'b0, ifc3.stallF}, 0);
    chk("lu3_run",     {30'b0, u3.state}, 0);
    chk("lu3_cnt",     {16'b0, ifc3.stall_cnt}, 3);

    // rdE = x0 never hazards
    loadUse(5'd0, 5'd0, 5'd0); #1;
    chk("x0_stall1",   {31'b0, ifc1.stallF}, 0);
    chk("x0_stall3",   {31'b0, ifc3.stallF}, 0);
    tick();

    // load-use, rs2 match: cnt1 -> 2, cnt3 -> 6
    loadUse(5'd7, 5'd1, 5'd7); #1;
    chk("lu2_stallD",  {31'b0, ifc1.stallD}, 1);
    tick();
    idle();
    tick();
    tick();
    chk("lu2_cnt1",    {29'b0, ifc1.stall_cnt}, 2);
    chk("lu2_cnt3",    {16'b0, ifc3.stall_cnt}, 6);

    // branch over load
    loadUse(5'd2, 5'd2, 5'd0); PCSrcE = 1'b1; apply(); #1;
    chk("br_flushD",   {31'b0, ifc3.flushD}, 1);
    chk("br_flushE",   {31'b0, ifc3.flushE}, 1);
    chk("br_stallF",   {31'b0, ifc3.stallF}, 0);
    chk("br_stallD",   {31'b0, ifc1.stallD}, 0);
    tick();
    idle();
    chk("br_cnt3",     {16'b0, ifc3.stall_cnt}, 6);

    // mul/div, done five cycles after start: cnt1 -> 7, cnt3 -> 11
    mduStart = 1'b1; apply();
    for (int k = 0; k < 6; k++) begin
      mduDone = (k == 5);
      PCSrcE  = (k == 2);
      apply(); #1;
      if (k < 5) begin
        chk($sformatf("mdu_stallE%0d", k), {31'b0, ifc3.stallE}, 1);
        chk($sformatf("mdu_flushM%0d", k), {31'b0, ifc1.flushM}, 1);
        if (k == 2) chk("mdu_noflD", {31'b0, ifc3.flushD}, 0);
      end else begin
        chk("mdu_rel_stF", {31'b0, ifc3.stallF}, 0);
        chk("mdu_rel_flM", {31'b0, ifc3.flushM}, 0);
      end
      tick();
    end
    idle(); #1;
    chk("mdu_run",     {31'b0, ifc3.stallF}, 0);
    chk("mdu_cnt1",    {29'b0, ifc1.stall_cnt}, 7);
    chk("mdu_cnt3",    {16'b0, ifc3.stall_cnt}, 11);

    // mul/div finishing in the start cycle
    mduStart = 1'b1; mduDone = 1'b1; apply(); #1;
    chk("mdu0_stallF", {31'b0, ifc3.stallF}, 0);
    chk("mdu0_flushM", {31'b0, ifc3.flushM}, 0);
    tick();
    idle();

    // 3-bit counter saturates at 7; 16-bit keeps counting to 14
    loadUse(5'd3, 5'd3, 5'd0);
    tick();
    idle();
    tick();
    tick();
    chk("sat_cnt1",    {29'b0, ifc1.stall_cnt}, 7);
    chk("sat_cnt3",    {16'b0, ifc3.stall_cnt}, 14);

    // forwarding
    rs1E = 5'd5; rdM = 5'd5; rdW = 5'd5; regwriteM = 1'b1; regwriteW = 1'b1; apply(); #1;
    chk("fwdA_mem",    {30'b0, ifc3.forwardAE}, 2);
    regwriteM = 1'b0; apply(); #1;
    chk("fwdA_wb",     {30'b0, ifc3.forwardAE}, 1);
    rs2E = 5'd0; rdM = 5'd0; rdW = 5'd3; regwriteM = 1'b1; apply(); #1;
    chk("fwdB_x0",     {30'b0, ifc3.forwardBE}, 0);
    rs2E = 5'd9; rdM = 5'd9; rdW = 5'd9; apply(); #1;
    chk("fwdB_mem",    {30'b0, ifc1.forwardBE}, 2);
    rs1E = 5'd0; rdW = 5'd0; regwriteM = 1'b0; apply(); #1;
    chk("fwdA_x0",     {30'b0, ifc1.forwardAE}, 0);
    idle();
    tick();

    // reset in the middle of MDU_WAIT
    mduStart = 1'b1; apply();
    tick();
    chk("rmdu_wait",   {31'b0, ifc3.stallE}, 1);
    rst = 1'b1; #1;
    chk("rmdu_stallF", {31'b0, ifc3.stallF}, 0);
    chk("rmdu_stallE", {31'b0, ifc1.stallE}, 0);
    chk("rmdu_flushM", {31'b0, ifc3.flushM}, 0);
    chk("rmdu_cnt1",   {29'b0, ifc1.stall_cnt}, 0);
    chk("rmdu_cnt3",   {16'b0, ifc3.stall_cnt}, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    chk("rmdu_post1",  {31'b0, ifc3.stallF}, 0);
    tick();
    chk("rmdu_post2",  {31'b0, ifc3.stallF}, 0);
    chk("rmdu_pcnt",   {16'b0, ifc3.stall_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
